// File: rtl/jt49_wrseq_if.sv
// jt49_wrseq_if: command handshake from the host and register bus towards the PSG.
interface jt49_wrseq_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_wait;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       psg_cs_n;
  logic       psg_wr_n;
  logic [3:0] psg_addr;
  logic [7:0] psg_din;
  modport master(
    output cmd_valid, cmd_wait, cmd_addr, cmd_data,
    input  cmd_ready, psg_cs_n, psg_wr_n, psg_addr, psg_din
  );
  modport slave(
    input  cmd_valid, cmd_wait, cmd_addr, cmd_data,
    output cmd_ready, psg_cs_n, psg_wr_n, psg_addr, psg_din
  );
endinterface

// File: rtl/jt49_wrseq.sv
// jt49_wrseq: buffers write/wait commands and replays them as PSG bus cycles with setup, strobe and hold phases.
module jt49_wrseq #(
  parameter int FIFO_AW  = 3,
  parameter int STRB_LEN = 2,
  parameter int HOLD_LEN = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               tick,
  input  logic               flush,
  jt49_wrseq_if.slave        bus,
  output logic               busy,
  output logic [FIFO_AW:0]   level
);
  localparam int DEPTH = 2 ** FIFO_AW;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, WAIT} state_t;
  state_t             state, state_nx;
  logic [12:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
  logic [11:0]        cnt, cnt_nx;
  logic               cs_n, wr_n, cs_nx, wr_nx, push, pop, empty;
  logic [3:0]         addr;
  logic [7:0]         din;
  logic [12:0]        head;
  assign head          = mem[rd_ptr];
  assign empty         = level == '0;
  assign bus.cmd_ready = level != (FIFO_AW+1)'(DEPTH);
  assign push          = bus.cmd_valid & bus.cmd_ready & ~flush;
  assign pop           = (state == IDLE) & cen & ~empty & ~flush;
  assign busy          = (state != IDLE) | ~empty;
  assign bus.psg_cs_n  = cs_n;
  assign bus.psg_wr_n  = wr_n;
  assign bus.psg_addr  = addr;
  assign bus.psg_din   = din;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {bus.cmd_wait, bus.cmd_addr, bus.cmd_data};
  always_ff @(posedge clk or posedge rst)
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      level  <= level + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
    end
  // A flush only cuts waits short; a bus cycle already started always runs to completion.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cs_nx    = cs_n;
    wr_nx    = wr_n;
    if (state == WAIT && flush) state_nx = IDLE;
    else if (cen)
      case (state)
        IDLE: if (pop) begin
          state_nx = head[12] ? WAIT : SETUP;
          cs_nx    = head[12];
          cnt_nx   = head[11:0];
        end
        SETUP: begin
          state_nx = STROBE;
          wr_nx    = 1'b0;
          cnt_nx   = 12'(STRB_LEN - 1);
        end
        STROBE: if (cnt == '0) begin
          state_nx = HOLD;
          wr_nx    = 1'b1;
          cnt_nx   = 12'(HOLD_LEN - 1);
        end else cnt_nx = cnt - 12'd1;
        HOLD: if (cnt == '0) begin
          state_nx = IDLE;
          cs_nx    = 1'b1;
        end else cnt_nx = cnt - 12'd1;
        WAIT: if (tick) begin
          state_nx = cnt == '0 ? IDLE : WAIT;
          cnt_nx   = cnt == '0 ? cnt : cnt - 12'd1;
        end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cs_n  <= 1'b1;
      wr_n  <= 1'b1;
      addr  <= '0;
      din   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cs_n  <= cs_nx;
      wr_n  <= wr_nx;
      if (pop && !head[12]) {addr, din} <= head[11:0];
    end
endmodule
